bank_select_ctrl: RTL
=====================

// Module: bank_select_ctrl
// PURPOSE
//  Parametrised register-bank pointer for the CPU register file: NUM_BANKS banks,
//  stepped up/down, directly loaded, or saved/restored via a LIFO context stack
//  (interrupt entry/return). Drives the bank index to the regfile address decode.
//  q is look-ahead: it shows the bank taking effect this cycle, so decode sees the new bank without a bubble.
// PARAMETERS
//  NUM_BANKS    4  number of banks, >=2, need not be a power of two
//  BANK_W       2  index width, must equal clog2(NUM_BANKS)
//  STACK_DEPTH  4  context-stack entries, >=1
//  WRAP         1  1: step wraps at ends; 0: step saturates at 0 / NUM_BANKS-1
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous reset, ACTIVE-LOW (0 = reset)
//  bank_en      in   1       step the bank one position this cycle
//  bank_dir     in   1       step direction: 0 = up (+1), 1 = down (-1)
//  bank_ld      in   1       load bank_ld_val
//  bank_ld_val  in   BANK_W  value for direct load
//  push         in   1       save current bank onto context stack
//  pop          in   1       restore bank from stack top
//  q            out  BANK_W  look-ahead bank index (combinational)
//  bank_cur     out  BANK_W  registered bank index
//  wrapped      out  1       registered 1-cycle pulse: last step wrapped around
//  stk_full     out  1       stack holds STACK_DEPTH entries (registered)
//  stk_empty    out  1       stack holds 0 entries (registered)
//  stk_err      out  1       registered 1-cycle pulse: overflow/underflow attempt
// BEHAVIOUR
//  Reset (rst==0 at edge): bank_cur=0, stack count=0, stk_empty=1, stk_full=0,
//   wrapped=0, stk_err=0; q forced to 0 while rst==0. Reset mid-op discards stack.
//  bank_nxt priority: pop (stack non-empty) > bank_ld > bank_en > hold.
//   pop    : bank_nxt = stack top.
//   ld     : bank_nxt = min(bank_ld_val, NUM_BANKS-1) (out-of-range clamps).
//   en up  : bank_cur==NUM_BANKS-1 -> 0 if WRAP, else hold; otherwise +1.
//   en down: bank_cur==0 -> NUM_BANKS-1 if WRAP, else hold; otherwise -1.
//  q = bank_nxt combinationally (zero latency); bank_cur <= bank_nxt (1 cycle).
//   With no action, q == bank_cur.
//  wrapped <= 1 only when the bank_en step is selected and actually wraps;
//   never on saturate, ld, or pop.
//  Stack (push saves pre-update bank_cur, i.e. the value before this cycle):
//   push only, not full  : store bank_cur, count+1.
//   push only, full      : dropped, count unchanged, stk_err pulse.
//   pop only, non-empty  : count-1, bank restored as above.
//   pop, empty           : ignored (ld/en apply normally), stk_err pulse.
//   push+pop, non-empty  : exchange: bank_nxt=top, top<=bank_cur, count same.
//   push+pop, empty      : treated as push only, stk_err pulse; ld/en apply.
//  stk_full/stk_empty reflect count after the edge. Max count is STACK_DEPTH.
//  Stack entries below the top are untouched by exchange.
//  stk_err and wrapped are 0 in any cycle without a triggering event.
// TESTING
//  Reset: drive rst=0 for 2 cycles -> bank_cur=0, q=0, stk_empty=1, stk_full=0, stk_err=0.
//  WRAP=1, NUM_BANKS=4: bank_en=1 for 5 cycles dir=0 -> bank_cur 1,2,3,0,1, wrapped
//   once at 3->0; q leads bank_cur by one cycle; dir=1 at 0 -> bank_cur 3.
//  WRAP=0, NUM_BANKS=5, BANK_W=3: step up from 4 -> bank_cur stays 4, wrapped=0;
//   ld 7 -> bank_cur 4 (clamp); ld 2 with en=1 same cycle -> 2.
//  STACK_DEPTH=2: push at bank 1, ld 3, push, then push again -> full,
//   stk_err pulse, count 2; pop -> 3, pop -> 1, empty; pop again -> stk_err, bank 1.
//  Exchange: stack top=2, bank_cur=0, push+pop -> bank_cur=2, top=0, count same.
//  Reset mid-op: stack count 2, rst=0 one cycle -> empty, bank_cur=0, pop then errs.

Source files
------------

// File: rtl/bank_select_if.sv
// Bank-select handshake bundle: step/load/stack controls in,
// look-ahead and registered bank index plus stack status out.
interface bank_select_if #(
  parameter int BANK_W = 2
);
  logic              bank_en;
  logic              bank_dir;
  logic              bank_ld;
  logic [BANK_W-1:0] bank_ld_val;
  logic              push;
  logic              pop;
  logic [BANK_W-1:0] q;
  logic [BANK_W-1:0] bank_cur;
  logic              wrapped;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_err;

  modport master (
    output bank_en, bank_dir, bank_ld, bank_ld_val,
    output push, pop,
    input  q, bank_cur, wrapped,
    input  stk_full, stk_empty, stk_err
  );

  modport slave (
    input  bank_en, bank_dir, bank_ld, bank_ld_val,
    input  push, pop,
    output q, bank_cur, wrapped,
    output stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/bank_select_ctrl.sv
// Register-bank pointer with step/load and a LIFO context stack.
// Ports: clk, rst (sync, active-low), bus (bank_select_if.slave).
module bank_select_ctrl #(
  parameter int NUM_BANKS   = 4,
  parameter int BANK_W      = 2,
  parameter int STACK_DEPTH = 4,
  parameter int WRAP        = 1
) (
  input  logic          clk,
  input  logic          rst,
  bank_select_if.slave  bus
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW =
    (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [BANK_W-1:0] LAST =
    BANK_W'(NUM_BANKS - 1);
  localparam logic [CW-1:0] FULL_CNT =
    CW'(STACK_DEPTH);

  logic [BANK_W-1:0] bank_q, bank_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BANK_W-1:0] stk_q [STACK_DEPTH];
  logic [BANK_W-1:0] stk_d [STACK_DEPTH];
  logic              wrapped_q, wrapped_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     wr_idx;
  logic              has_top;
  logic              is_full;

  always_comb begin
    has_top   = (cnt_q != '0);
    is_full   = (cnt_q == FULL_CNT);
    top_idx   = IW'(cnt_q - 1'b1);
    wr_idx    = IW'(cnt_q);
    bank_d    = bank_q;
    cnt_d     = cnt_q;
    stk_d     = stk_q;
    wrapped_d = 1'b0;
    err_d     = 1'b0;

    if (bus.pop && has_top) begin
      bank_d = stk_q[top_idx];
      // push+pop swaps in place; depth unchanged
      if (bus.push) stk_d[top_idx] = bank_q;
      else          cnt_d = cnt_q - 1'b1;
    end else begin
      if (bus.bank_ld) begin
        bank_d = (bus.bank_ld_val > LAST) ?
                 LAST : bus.bank_ld_val;
      end else if (bus.bank_en) begin
        if (!bus.bank_dir) begin
          if (bank_q == LAST) begin
            if (WRAP != 0) begin
              bank_d    = '0;
              wrapped_d = 1'b1;
            end
          end else begin
            bank_d = bank_q + 1'b1;
          end
        end else begin
          if (bank_q == '0) begin
            if (WRAP != 0) begin
              bank_d    = LAST;
              wrapped_d = 1'b1;
            end
          end else begin
            bank_d = bank_q - 1'b1;
          end
        end
      end
      // pop reaching here means the stack was empty
      if (bus.pop) err_d = 1'b1;
      if (bus.push) begin
        if (is_full) begin
          err_d = 1'b1;
        end else begin
          stk_d[wr_idx] = bank_q;
          cnt_d         = cnt_q + 1'b1;
        end
      end
    end

    full_d  = (cnt_d == FULL_CNT);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_q    <= '0;
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      bank_q    <= bank_d;
      cnt_q     <= cnt_d;
      wrapped_q <= wrapped_d;
      err_q     <= err_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  // entries above the count are dead, so no reset needed
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign bus.q         = rst ? bank_d : '0;
  assign bus.bank_cur  = bank_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.stk_full  = full_q;
  assign bus.stk_empty = empty_q;
  assign bus.stk_err   = err_q;
endmodule
